// File: rtl/muldiv_sequencer.sv
// Iterative RV64 M-extension unit: radix-2 shift-add multiply / restoring divide, K=64 (K=32 for W ops).
// Latency K+2 cycles accept-to-done (1 for fast divide specials); stall_o holds the pipe from accept through FIX.
module muldiv_sequencer #(
  parameter bit FAST_SPECIAL = 1'b1,
  parameter int XLEN         = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            kill_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int WL = 32;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        cnt_q;
  logic [2:0]        op_q;
  logic              word_q;
  logic              neg_q;
  logic [XLEN-1:0]   hi_q, lo_q, opb_q, result_q;

  logic              accept;
  logic [2:0]        op_in;
  logic              is_div_in, a_signed, b_signed, a_neg, b_neg, b_zero, ovf, special;
  logic [XLEN-1:0]   a_val, b_val, a_mag, b_mag, min_val, special_res;

  assign accept = (state_q == S_IDLE) & start_i & ~kill_i;

  // W forms of MULH* collapse to MULW; all signed work is done on magnitudes.
  always_comb begin
    op_in       = (word_i & ~funct3_i[2]) ? 3'b000 : funct3_i;
    is_div_in   = op_in[2];
    a_signed    = is_div_in ? ~op_in[0] : ((op_in == 3'b001) | (op_in == 3'b010));
    b_signed    = is_div_in ? ~op_in[0] : (op_in == 3'b001);
    a_val       = word_i ? {{(XLEN-WL){a_signed & op1_i[WL-1]}}, op1_i[WL-1:0]} : op1_i;
    b_val       = word_i ? {{(XLEN-WL){b_signed & op2_i[WL-1]}}, op2_i[WL-1:0]} : op2_i;
    a_neg       = a_signed & a_val[XLEN-1];
    b_neg       = b_signed & b_val[XLEN-1];
    a_mag       = a_neg ? -a_val : a_val;
    b_mag       = b_neg ? -b_val : b_val;
    min_val     = word_i ? {{(XLEN-WL+1){1'b1}}, {(WL-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    b_zero      = (b_val == '0);
    ovf         = is_div_in & a_signed & (a_val == min_val) & (b_val == '1);
    special     = is_div_in & (b_zero | ovf);
    special_res = '0;
    if (op_in[1]) special_res = b_zero ? a_val : '0;
    else          special_res = b_zero ? '1 : a_val;
    if (word_i)   special_res = {{(XLEN-WL){special_res[WL-1]}}, special_res[WL-1:0]};
  end

  logic [XLEN:0]     mul_sum, div_shl;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + ({1'b0, opb_q} & {(XLEN+1){lo_q[0]}});
    div_shl  = {hi_q, lo_q[XLEN-1]};
    div_ge   = (div_shl >= {1'b0, opb_q});
    div_diff = div_shl[XLEN-1:0] - opb_q;
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res, div_raw, div_s, div_res, fix_res;

  // W multiply leaves its 32-bit product in lo_q's upper half after 32 steps.
  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = neg_q ? -prod : prod;
    if (word_q)              mul_res = {{(XLEN-WL){lo_q[XLEN-1]}}, lo_q[XLEN-1:XLEN-WL]};
    else if (op_q[1:0] == 0) mul_res = prod_s[XLEN-1:0];
    else                     mul_res = prod_s[2*XLEN-1:XLEN];
    div_raw = op_q[1] ? hi_q : lo_q;
    div_s   = neg_q ? -div_raw : div_raw;
    div_res = word_q ? {{(XLEN-WL){div_s[WL-1]}}, div_s[WL-1:0]} : div_s;
    fix_res = op_q[2] ? div_res : mul_res;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_in;
        word_q <= word_i;
        neg_q  <= is_div_in ? (op_in[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero)) : (a_neg ^ b_neg);
        cnt_q  <= word_i ? 6'd31 : 6'd63;
        hi_q   <= '0;
        opb_q  <= is_div_in ? b_mag : a_mag;
        // W dividend is pre-shifted so its MSB is the first bit into the remainder.
        lo_q   <= is_div_in ? (word_i ? {a_mag[WL-1:0], {(XLEN-WL){1'b0}}} : a_mag) : b_mag;
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_q - 6'd1;
        if (op_q[2]) begin
          hi_q <= div_ge ? div_diff : div_shl[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_q <= mul_sum[XLEN:1];
          lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
        end
      end
      if ((state_q == S_FIX) && !kill_i)            result_q <= fix_res;
      else if (accept && FAST_SPECIAL && special)   result_q <= special_res;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = accept;
        if (accept) state_d = (FAST_SPECIAL && special) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        stall_o = 1'b1;
        busy_o  = 1'b1;
        if (cnt_q == 6'd0) state_d = S_FIX;
      end
      S_FIX: begin
        stall_o = 1'b1;
        busy_o  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: result, latency, stall window, plus kill and async-reset sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic        word;
  logic [63:0] op1, op2;
  logic        kill;
  logic        stall, busy, done;
  logic [63:0] result;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_sequencer #(.FAST_SPECIAL(1'b1), .XLEN(64)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .funct3_i (funct3),
    .word_i   (word),
    .op1_i    (op1),
    .op2_i    (op2),
    .kill_i   (kill),
    .stall_o  (stall),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic [7:0]  lat;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  // Starts one op in the current IDLE cycle and returns once done_o is seen (or a budget runs out).
  // While the op is in flight, start and operands are scrambled; none of that may be picked up.
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output int stalls, output int early);
    logic [63:0] prev;
    prev   = result;
    start  = 1'b1;
    funct3 = f3;
    word   = w;
    op1    = a;
    op2    = b;
    kill   = 1'b0;
    #1;
    stalls = int'(stall);
    @(posedge clk);
    #1;
    lat   = 1;
    early = 0;
    while (!done && lat < 200) begin
      stalls += int'(stall);
      if (result !== prev) early++;
      start  = 1'($urandom_range(0, 1));
      funct3 = 3'($urandom_range(0, 7));
      word   = 1'($urandom_range(0, 1));
      op1    = {$urandom, $urandom};
      op2    = {$urandom, $urandom};
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    res   = result;
  endtask

  initial begin
    logic [63:0] res, prev;
    int lat, stalls, early;

    vecs[0]  = '{3'b000, 1'b0, 64'd3,                   64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 8'd66};
    vecs[1]  = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 8'd66};
    vecs[2]  = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 8'd66};
    vecs[3]  = '{3'b101, 1'b0, 64'd5,                   64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 8'd1};
    vecs[4]  = '{3'b111, 1'b0, 64'd5,                   64'd0,                   64'd5,                   8'd1};
    vecs[5]  = '{3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 8'd66};
    vecs[6]  = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 8'd1};
    vecs[7]  = '{3'b100, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 8'd1};
    vecs[8]  = '{3'b111, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2,                   64'd1,                   8'd34};
    vecs[9]  = '{3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 8'd66};
    vecs[10] = '{3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd66};
    vecs[11] = '{3'b100, 1'b0, 64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 8'd66};
    vecs[12] = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,                   8'd66};
    vecs[13] = '{3'b011, 1'b1, 64'hAAAA_0000_7FFF_FFFF, 64'h1234_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 8'd34};
    vecs[14] = '{3'b101, 1'b1, 64'h5555_5555_FFFF_FFFF, 64'hFFFF_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 8'd34};
    vecs[15] = '{3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 8'd34};
    vecs[16] = '{3'b101, 1'b1, 64'd5,                   64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1};
    vecs[17] = '{3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   8'd1};
    vecs[18] = '{3'b000, 1'b0, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0001, 8'd66};

    rst    = 1'b0;
    start  = 1'b0;
    kill   = 1'b0;
    funct3 = 3'b000;
    word   = 1'b0;
    op1    = '0;
    op2    = '0;
    #1;
    check("reset_busy",   64'(busy),   64'd0);
    check("reset_done",   64'(done),   64'd0);
    check("reset_stall",  64'(stall),  64'd0);
    check("reset_result", result,      64'd0);
    #11 rst = 1'b1;
    @(posedge clk);
    #1;

    // Vectors run back to back: each start lands in the first IDLE cycle after the previous DONE.
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, res, lat, stalls, early);
      check($sformatf("v%0d_result", i),     res,           vecs[i].exp);
      check($sformatf("v%0d_latency", i),    64'(lat),      64'(vecs[i].lat));
      check($sformatf("v%0d_stall_cyc", i),  64'(stalls),   64'(vecs[i].lat));
      check($sformatf("v%0d_early_res", i),  64'(early),    64'd0);
      check($sformatf("v%0d_stall_done", i), 64'(stall),    64'd0);
      @(posedge clk);
      #1;
    end

    // Kill in the 10th CALC cycle, then restart in the very next cycle.
    prev   = result;
    start  = 1'b1;
    funct3 = 3'b101;
    word   = 1'b0;
    op1    = 64'd100;
    op2    = 64'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("kill_pre_busy", 64'(busy), 64'd1);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_stall",  64'(stall), 64'd0);
    check("kill_busy",   64'(busy),  64'd0);
    check("kill_done",   64'(done),  64'd0);
    check("kill_result", result,     prev);
    run_op(3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, res, lat, stalls, early);
    check("kill_restart_result",  res,        64'hFFFF_FFFF_FFFF_FFF1);
    check("kill_restart_latency", 64'(lat),   64'd66);
    check("kill_restart_stall",   64'(stalls), 64'd66);
    check("kill_restart_early",   64'(early), 64'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC, away from any clock edge.
    start  = 1'b1;
    funct3 = 3'b011;
    word   = 1'b0;
    op1    = '1;
    op2    = '1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_busy",   64'(busy),  64'd0);
    check("rst_mid_done",   64'(done),  64'd0);
    check("rst_mid_stall",  64'(stall), 64'd0);
    check("rst_mid_result", result,     64'd0);
    @(posedge clk);
    #1;
    check("rst_hold_busy", 64'(busy), 64'd0);
    #2 rst = 1'b1;
    run_op(3'b101, 1'b0, 64'd100, 64'd7, res, lat, stalls, early);
    check("rst_restart_result",  res,      64'd14);
    check("rst_restart_latency", 64'(lat), 64'd66);
    check("rst_restart_early",   64'(early), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter FAST_SPECIAL, default 1, meaning: divide-by-zero and signed-overflow divides complete without iterating.
REQ-002 Parameter XLEN, default 64, meaning: datapath width; 64 is the only supported value.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  request to begin an M-extension operation.
REQ-006 funct3_i  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 word_i  input  1  selects the W variant (32-bit operation on the low halves).
REQ-008 op1_i, op2_i  input  64 each  operands (rs1 = multiplicand/dividend, rs2 = multiplier/divisor).
REQ-009 kill_i  input  1  pipeline flush; aborts any operation.
REQ-010 stall_o  output  1  holds the execute stage while an operation is in flight.
REQ-011 busy_o  output  1  high in CALC and FIX.
REQ-012 done_o  output  1  one-cycle pulse; result_o is valid.
REQ-013 result_o  output  64  operation result; held until the next accepted start.

Function
REQ-014 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-015 A start SHALL be accepted on a rising edge in IDLE when start_i=1 and kill_i=0; the edge latches the operation, the word flag, the operand magnitudes and the result-sign flags.
REQ-016 The iteration count SHALL be K=64 with word_i=0 and K=32 with word_i=1.
REQ-017 CALC SHALL last exactly K cycles, using one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 Transitions SHALL be: CALC -> FIX (sign correction, high/low select, W sign-extension) -> DONE -> IDLE.
REQ-019 done_o SHALL be high only in DONE, exactly K+2 cycles after the accept edge.
REQ-020 stall_o SHALL equal (IDLE & start_i & ~kill_i) | CALC | FIX, and SHALL be low in DONE so the pipeline captures result_o.
REQ-021 MUL SHALL return the low 64 bits; MULH, MULHSU and MULHU SHALL return the high 64 bits with operands signed/signed, signed/unsigned and unsigned/unsigned respectively.
REQ-022 DIV and REM SHALL truncate toward zero, and the sign of the remainder SHALL equal the sign of the dividend.
REQ-023 Divide by zero SHALL return quotient all-ones and remainder equal to the dividend.
REQ-024 Signed overflow (most-negative / -1) SHALL return quotient equal to the dividend and remainder 0.
REQ-025 With FAST_SPECIAL=1, the cases in REQ-023/REQ-024 SHALL go IDLE -> DONE, so done_o is high 1 cycle after accept; with FAST_SPECIAL=0 they SHALL iterate and yield the same values.
REQ-026 With word_i=1, only op[31:0] SHALL be used, and the 32-bit result SHALL be sign-extended from bit 31 (including DIVUW and REMUW).
REQ-027 word_i=1 with funct3 001, 010 or 011 SHALL behave as MULW.
REQ-028 start_i outside IDLE SHALL be ignored.
REQ-029 kill_i=1 in any state SHALL force IDLE on the next edge with no done_o; result_o SHALL keep its previous value.
REQ-030 start_i and kill_i both high in IDLE SHALL not be accepted.
REQ-031 A start SHALL be acceptable in the first IDLE cycle after DONE (back-to-back throughput K+3 cycles).
REQ-032 Operand inputs SHALL be sampled only on the accept edge; later changes SHALL have no effect.

Reset
REQ-033 rst_i low SHALL immediately force IDLE, busy_o=0, done_o=0, result_o=0 and all internal registers to 0, independent of clk_i.
REQ-034 A reset asserted mid-operation SHALL discard that operation, produce no done_o, and allow a start to be accepted on the first edge after rst_i rises.

Verification
REQ-035 Bench SHALL cover MUL, op1=3, op2=-5 -> done_o at accept+66, result 0xFFFFFFFFFFFFFFF1; stall_o high for 66 cycles including the accept cycle.
REQ-036 Bench SHALL cover DIV -7/2 -> 0xFFFFFFFFFFFFFFFD, and REM -7/2 -> 0xFFFFFFFFFFFFFFFF.
REQ-037 Bench SHALL cover DIVU 5/0 -> 0xFFFFFFFFFFFFFFFF at accept+1 (FAST_SPECIAL=1), and REMU 5/0 -> 5.
REQ-038 Bench SHALL cover MULHU all-ones x all-ones -> 0xFFFFFFFFFFFFFFFE, and DIV 0x8000000000000000 / -1 -> 0x8000000000000000.
REQ-039 Bench SHALL cover DIVW op1=0x0000000180000000, op2=-1 -> 0xFFFFFFFF80000000, and REMUW 0x00000000FFFFFFFF / 2 -> 0x0000000000000001, each within K=32 timing (done_o at accept+34 for REMUW).
REQ-040 Bench SHALL cover kill_i at CALC cycle 10 -> no done_o, stall_o low on the next cycle, a new start accepted immediately, and result_o unchanged until that operation's done_o; and rst_i pulsed mid-CALC -> outputs 0 asynchronously.
